// File: rtl/quiz_round_ctrl.sv
// Round sequencer and buzzer arbiter for a 4-player quiz: arms buzzers, grants one player,
// times buzz/answer windows, emits one-cycle score/timeout/foul pulses and counts rounds.
module quiz_round_ctrl #(
   parameter int unsigned TICKS_PER_SEC = 100_000_000,
   parameter int unsigned BUZZ_SEC      = 10,
   parameter int unsigned ANSWER_SEC    = 20,
   parameter int unsigned MAX_ROUND     = 99
) (
   input  logic       clk,
   input  logic       resetButton,
   input  logic       game_en,
   input  logic       host,
   input  logic [3:0] people,
   input  logic       isRight,
   input  logic       isWrong,
   output logic [3:0] lock_people,
   output logic [1:0] isAdd,
   output logic       isOverTime,
   output logic       isFoul,
   output logic [3:0] foul_people,
   output logic [2:0] phase,
   output logic [7:0] countdown,
   output logic [7:0] roundNumber
);
   localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      ANSWER  = 3'd2,
      SCORE   = 3'd3,
      RELEASE = 3'd4
   } state_t;

   state_t        state, state_n;
   logic          host_q;
   logic [3:0]    people_q;
   logic [1:0]    rr_ptr, rr_n;
   logic [TW-1:0] tick, tick_n;
   logic [7:0]    cd_n, rnd_n, rnd_inc;
   logic [3:0]    lock_n, foulp_n, people_rise;
   logic [1:0]    add_n, win, idx;
   logic          ot_n, foul_n, found, host_rise, host_fall, wrap, expire;

   assign host_rise   = host & ~host_q;
   assign host_fall   = ~host & host_q;
   assign people_rise = people & ~people_q;
   assign wrap        = (tick == TICK_MAX);
   assign expire      = wrap && (countdown <= 8'd1);
   assign rnd_inc     = (roundNumber < 8'(MAX_ROUND)) ? roundNumber + 8'd1 : roundNumber;
   assign phase       = state;

   // Round-robin pick among currently pressed buzzers, starting at rr_ptr.
   always_comb begin
      win   = 2'd0;
      idx   = 2'd0;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = rr_ptr + 2'(k);
         if (!found && people[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_n = state;
      tick_n  = tick;
      cd_n    = countdown;
      lock_n  = lock_people;
      rnd_n   = roundNumber;
      rr_n    = rr_ptr;
      add_n   = 2'b00;
      ot_n    = 1'b0;
      foul_n  = 1'b0;
      foulp_n = 4'b0000;
      if (!game_en) begin
         state_n = IDLE;
         tick_n  = '0;
         cd_n    = 8'd0;
         lock_n  = 4'b0000;
      end else begin
         case (state)
            IDLE: begin
               lock_n = 4'b0000;
               cd_n   = 8'd0;
               tick_n = '0;
               if (host_rise) begin
                  state_n = ARMED;
                  cd_n    = 8'(BUZZ_SEC);
               end else if (!host && people_rise != 4'b0000) begin
                  foul_n  = 1'b1;
                  foulp_n = people_rise & (~people_rise + 4'd1);
               end
            end
            ARMED: begin
               if (host_fall) begin
                  state_n = IDLE;
                  cd_n    = 8'd0;
                  tick_n  = '0;
               end else if (found) begin
                  state_n = ANSWER;
                  lock_n  = 4'b0001 << win;
                  rr_n    = win + 2'd1;
                  cd_n    = 8'(ANSWER_SEC);
                  tick_n  = '0;
               end else if (expire) begin
                  state_n = RELEASE;
                  ot_n    = 1'b1;
                  rnd_n   = rnd_inc;
                  cd_n    = 8'd0;
                  tick_n  = '0;
               end else begin
                  tick_n = wrap ? '0 : tick + TW'(1);
                  if (wrap) cd_n = countdown - 8'd1;
               end
            end
            ANSWER: begin
               if (host_fall) begin
                  state_n = IDLE;
                  lock_n  = 4'b0000;
                  cd_n    = 8'd0;
                  tick_n  = '0;
               end else if (isRight ^ isWrong) begin
                  state_n = SCORE;
                  add_n   = isRight ? 2'b01 : 2'b10;
                  rnd_n   = rnd_inc;
                  cd_n    = 8'd0;
                  tick_n  = '0;
               end else if (expire) begin
                  // Answer timeout scores as a wrong answer.
                  state_n = SCORE;
                  ot_n    = 1'b1;
                  add_n   = 2'b10;
                  rnd_n   = rnd_inc;
                  cd_n    = 8'd0;
                  tick_n  = '0;
               end else begin
                  tick_n = wrap ? '0 : tick + TW'(1);
                  if (wrap) cd_n = countdown - 8'd1;
               end
            end
            SCORE: state_n = RELEASE;
            RELEASE: begin
               if (!host && people == 4'b0000 && !isRight && !isWrong) begin
                  state_n = IDLE;
                  lock_n  = 4'b0000;
               end
            end
            default: begin
               state_n = IDLE;
               lock_n  = 4'b0000;
               cd_n    = 8'd0;
               tick_n  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge resetButton) begin
      if (resetButton) begin
         state       <= IDLE;
         host_q      <= 1'b0;
         people_q    <= 4'b0000;
         rr_ptr      <= 2'd0;
         tick        <= '0;
         countdown   <= 8'd0;
         lock_people <= 4'b0000;
         isAdd       <= 2'b00;
         isOverTime  <= 1'b0;
         isFoul      <= 1'b0;
         foul_people <= 4'b0000;
         roundNumber <= 8'd0;
      end else begin
         state       <= state_n;
         host_q      <= host;
         people_q    <= people;
         rr_ptr      <= rr_n;
         tick        <= tick_n;
         countdown   <= cd_n;
         lock_people <= lock_n;
         isAdd       <= add_n;
         isOverTime  <= ot_n;
         isFoul      <= foul_n;
         foul_people <= foulp_n;
         roundNumber <= rnd_n;
      end
   end
endmodule
